// File: rtl/access_session_ctrl_if.sv
// Channel bundle for one access session: decoded auth-level and feature-request lines in,
// session status and grant/deny results out.
interface access_session_ctrl_if;
    logic       ATadm;
    logic       ATtest;
    logic       ATuser;
    logic       ATguest;
    logic [6:0] FT;
    logic       ACTIVE;
    logic [1:0] LVL;
    logic [6:0] GRANT;
    logic       DENY;
    logic       TOUT;
    logic       LOCK;

    modport master (
        output ATadm, ATtest, ATuser, ATguest, FT,
        input  ACTIVE, LVL, GRANT, DENY, TOUT, LOCK
    );

    modport slave (
        input  ATadm, ATtest, ATuser, ATguest, FT,
        output ACTIVE, LVL, GRANT, DENY, TOUT, LOCK
    );
endinterface

// File: rtl/access_session_ctrl.sv
// Per-channel login session controller: debounced login/logout, level latch, feature permission check
// and idle timeout. Define LOCKOUT_EN to add the consecutive-denial lockout state.
module access_session_ctrl #(
    parameter int DEB_CYC     = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYC    = 500,
    parameter int CW          = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    access_session_ctrl_if.slave  bus
);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYC);

    if (DEB_CYC < 2 || TIMEOUT_CYC < 2 || MAX_FAIL < 1 || LOCK_CYC < 1) begin : g_bad_cfg
        $error("access_session_ctrl: parameter out of range");
    end

`ifdef LOCKOUT_EN
    localparam logic [CW-1:0] FAIL_LAST = CW'(MAX_FAIL - 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYC);
    typedef enum logic [1:0] {LOCKED, SESSION, LOCKOUT} state_t;
`else
    typedef enum logic [1:0] {LOCKED, SESSION} state_t;
`endif

    function automatic logic onehot7(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

    function automatic logic [1:0] enc_lvl(input logic [3:0] a);
        if (a[3])      return 2'd3;
        else if (a[2]) return 2'd2;
        else if (a[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic permitted(input logic [6:0] ft, input logic [1:0] lvl);
        logic [6:0] mask;
        case (lvl)
            2'd3:    mask = 7'h7F;
            2'd2:    mask = 7'h1F;
            2'd1:    mask = 7'h07;
            default: mask = 7'h01;
        endcase
        return (ft & ~mask) == 7'd0;
    endfunction

    state_t        state;
    logic [3:0]    at_p0, at_p1, at_p2;
    logic [6:0]    ft_p0, ft_p1, ft_p2;
    logic [CW-1:0] deb_cnt, idle_cnt;
    logic [1:0]    lvl_q;
    logic [6:0]    grant_q;
    logic          active_q, deny_q, tout_q;
`ifdef LOCKOUT_EN
    logic [CW-1:0] fail_cnt, lock_cnt;
    logic          lock_q;
`endif

    logic          deb_cond, deb_done, ft_chg, ft_ok, req_grant, req_deny, idle_done;
    logic [CW-1:0] deb_nxt;

    // _p1 is the synchronized value, _p2 its previous-cycle copy for change detection
    always_comb begin
        deb_cond  = (state == SESSION) ? (at_p1 == 4'd0) : onehot7({3'b000, at_p1});
        deb_done  = 1'b0;
        deb_nxt   = '0;
        if (deb_cond) begin
            if (at_p1 != at_p2)          deb_nxt  = CW'(1);
            else if (deb_cnt == DEB_LAST) deb_done = 1'b1;
            else                          deb_nxt  = deb_cnt + 1'b1;
        end
        ft_chg    = (ft_p1 != ft_p2);
        ft_ok     = onehot7(ft_p1);
        req_grant = ft_ok && permitted(ft_p1, lvl_q);
        req_deny  = ft_ok && !permitted(ft_p1, lvl_q) && ft_chg;
        idle_done = !ft_chg && (idle_cnt == CW'(1));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= LOCKED;
            at_p0    <= '0;
            at_p1    <= '0;
            at_p2    <= '0;
            ft_p0    <= '0;
            ft_p1    <= '0;
            ft_p2    <= '0;
            deb_cnt  <= '0;
            idle_cnt <= '0;
            lvl_q    <= '0;
            grant_q  <= '0;
            active_q <= 1'b0;
            deny_q   <= 1'b0;
            tout_q   <= 1'b0;
`ifdef LOCKOUT_EN
            fail_cnt <= '0;
            lock_cnt <= '0;
            lock_q   <= 1'b0;
`endif
        end else begin
            at_p0  <= {bus.ATadm, bus.ATtest, bus.ATuser, bus.ATguest};
            at_p1  <= at_p0;
            at_p2  <= at_p1;
            ft_p0  <= bus.FT;
            ft_p1  <= ft_p0;
            ft_p2  <= ft_p1;
            deny_q <= 1'b0;
            tout_q <= 1'b0;
            case (state)
                LOCKED: begin
                    deb_cnt <= deb_nxt;
                    if (deb_done) begin
                        state    <= SESSION;
                        lvl_q    <= enc_lvl(at_p1);
                        active_q <= 1'b1;
                        deb_cnt  <= '0;
                        idle_cnt <= TO_LOAD;
                    end
                end
                SESSION: begin
                    deb_cnt  <= deb_nxt;
                    grant_q  <= req_grant ? ft_p1 : 7'd0;
                    deny_q   <= req_deny;
                    idle_cnt <= ft_chg ? TO_LOAD : idle_cnt - 1'b1;
`ifdef LOCKOUT_EN
                    if (req_grant)     fail_cnt <= '0;
                    else if (req_deny) fail_cnt <= fail_cnt + 1'b1;
`endif
                    // exit priority: logout, then lockout, then idle timeout
                    if (deb_done) begin
                        state    <= LOCKED;
                        active_q <= 1'b0;
                        grant_q  <= '0;
                        deb_cnt  <= '0;
`ifdef LOCKOUT_EN
                        fail_cnt <= '0;
                    end else if (req_deny && fail_cnt == FAIL_LAST) begin
                        state    <= LOCKOUT;
                        active_q <= 1'b0;
                        grant_q  <= '0;
                        lock_q   <= 1'b1;
                        lock_cnt <= LOCK_LOAD;
                        fail_cnt <= '0;
`endif
                    end else if (idle_done) begin
                        state    <= LOCKED;
                        active_q <= 1'b0;
                        grant_q  <= '0;
                        tout_q   <= 1'b1;
                        deb_cnt  <= '0;
`ifdef LOCKOUT_EN
                        fail_cnt <= '0;
`endif
                    end
                end
`ifdef LOCKOUT_EN
                LOCKOUT: begin
                    lock_cnt <= lock_cnt - 1'b1;
                    if (lock_cnt == CW'(1)) begin
                        state   <= LOCKED;
                        lock_q  <= 1'b0;
                        deb_cnt <= '0;
                    end
                end
`endif
                default: state <= LOCKED;
            endcase
        end
    end

    assign bus.ACTIVE = active_q;
    assign bus.LVL    = lvl_q;
    assign bus.GRANT  = grant_q;
    assign bus.DENY   = deny_q;
    assign bus.TOUT   = tout_q;
`ifdef LOCKOUT_EN
    assign bus.LOCK   = lock_q;
`else
    assign bus.LOCK   = 1'b0;
`endif
endmodule

// File: tb/tb_access_session_ctrl.sv
// Directed bench for access_session_ctrl with DEB_CYC=4, TIMEOUT_CYC=20, MAX_FAIL=2, LOCK_CYC=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_access_session_ctrl;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    access_session_ctrl_if bus();

    access_session_ctrl #(
        .DEB_CYC(4), .TIMEOUT_CYC(20), .MAX_FAIL(2), .LOCK_CYC(10), .CW(16)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_at(input logic [3:0] a);
        {bus.ATadm, bus.ATtest, bus.ATuser, bus.ATguest} = a;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, 32'(bus.ACTIVE), 0);
        check({tag, "_lvl"},    32'(bus.LVL),    0);
        check({tag, "_grant"},  32'(bus.GRANT),  0);
        check({tag, "_deny"},   32'(bus.DENY),   0);
        check({tag, "_tout"},   32'(bus.TOUT),   0);
        check({tag, "_lock"},   32'(bus.LOCK),   0);
    endtask

    task automatic wait_active(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (bus.ACTIVE) break;
            step(1);
        end
        check(tag, 32'(bus.ACTIVE), 1);
    endtask

    initial begin
        int cnt;
        int lat;
        set_at(4'b0000);
        bus.FT = 7'd0;

        // reset state
        step(3);
        check_all_zero("reset");
        RSTN = 1'b1;
        step(2);
        check_all_zero("post_reset");

        // 1: glitching ATuser never opens a session, held ATuser opens on edge 6
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            bus.ATuser = ~bus.ATuser;
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (bus.ACTIVE) cnt++;
            end
        end
        bus.ATuser = 1'b0;
        step(4);
        check("glitch_no_active", 32'(cnt), 0);
        set_at(4'b0010);
        step(5);
        check("login_edge5", 32'(bus.ACTIVE), 0);
        step(1);
        check("login_edge6", 32'(bus.ACTIVE), 1);
        check("login_lvl", 32'(bus.LVL), 1);

        // 2: permitted request granted after 3 edges, denied request pulses once
        bus.FT = 7'b0000100;
        step(2);
        check("grant_edge2", 32'(bus.GRANT), 0);
        step(1);
        check("grant_edge3", 32'(bus.GRANT), 7'b0000100);
        bus.FT = 7'b0001000;
        step(3);
        check("deny_grant", 32'(bus.GRANT), 0);
        check("deny_pulse", 32'(bus.DENY), 1);
        cnt = 0;
        for (int j = 0; j < 5; j++) begin
            step(1);
            if (bus.DENY) cnt++;
        end
        check("deny_held_quiet", 32'(cnt), 0);

        // 3: constant FT times out 20 edges after the change is seen (edge 3 + 20)
        bus.FT = 7'b0000010;
        step(3);
        check("t3_grant", 32'(bus.GRANT), 7'b0000010);
        lat = 0;
        for (int i = 4; i <= 40; i++) begin
            step(1);
            if (bus.TOUT) begin
                lat = i;
                break;
            end
        end
        check("tout_latency", 32'(lat), 23);
        check("tout_active", 32'(bus.ACTIVE), 0);
        check("tout_grant", 32'(bus.GRANT), 0);
        step(1);
        check("tout_one_pulse", 32'(bus.TOUT), 0);

        // held ATuser logs in again; then toggle FT every 10 cycles
        wait_active("relogin_user");
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.FT = bus.FT ^ 7'b0000011;
            for (int j = 0; j < 10; j++) begin
                step(1);
                if (bus.TOUT) cnt++;
            end
        end
        check("toggle_no_tout", 32'(cnt), 0);
        check("toggle_active", 32'(bus.ACTIVE), 1);

        // 4: logout after 4 stable all-zero cycles, no TOUT
        set_at(4'b0000);
        bus.FT = 7'd0;
        step(5);
        check("logout_edge5", 32'(bus.ACTIVE), 1);
        step(1);
        check("logout_edge6", 32'(bus.ACTIVE), 0);
        check("logout_tout", 32'(bus.TOUT), 0);
        check("logout_grant", 32'(bus.GRANT), 0);

        // guest session ignores a switch to ATadm
        set_at(4'b0001);
        step(6);
        check("guest_active", 32'(bus.ACTIVE), 1);
        check("guest_lvl", 32'(bus.LVL), 0);
        set_at(4'b1000);
        step(10);
        check("relevel_lvl", 32'(bus.LVL), 0);
        check("relevel_active", 32'(bus.ACTIVE), 1);
        bus.FT = 7'b0000001;
        step(3);
        check("guest_ft0", 32'(bus.GRANT), 7'b0000001);

        // 5: two consecutive denials
        bus.FT = 7'b0001000;
        step(3);
        check("deny1_pulse", 32'(bus.DENY), 1);
        check("deny1_active", 32'(bus.ACTIVE), 1);
        bus.FT = 7'b0100000;
        step(3);
        check("deny2_pulse", 32'(bus.DENY), 1);
        check("deny2_grant", 32'(bus.GRANT), 0);
`ifdef LOCKOUT_EN
        check("lockout_lock", 32'(bus.LOCK), 1);
        check("lockout_active", 32'(bus.ACTIVE), 0);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!bus.LOCK) break;
            cnt++;
        end
        check("lockout_len", 32'(cnt), 10);
        check("after_lock_active", 32'(bus.ACTIVE), 0);
        wait_active("relogin_adm");
        check("relogin_adm_lvl", 32'(bus.LVL), 3);
`else
        check("nolock_lock", 32'(bus.LOCK), 0);
        check("nolock_active", 32'(bus.ACTIVE), 1);
        step(5);
        check("nolock_still_active", 32'(bus.ACTIVE), 1);
        check("nolock_still_nolock", 32'(bus.LOCK), 0);
`endif

        // 6: async reset mid-session with a live grant
        wait_active("pre_reset_active");
        bus.FT = 7'b0000001;
        step(3);
        check("pre_reset_grant", 32'(bus.GRANT), 7'b0000001);
        #2 RSTN = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge CLK);
        RSTN = 1'b1;
        check_all_zero("reset_release");
        step(5);
        check("rst_login_edge5", 32'(bus.ACTIVE), 0);
        step(1);
        check("rst_login_edge6", 32'(bus.ACTIVE), 1);
        check("rst_login_lvl", 32'(bus.LVL), 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
